// File: rtl/fmap_read_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fmap_read_seq_if
// Description : Bundles the job, scratch-pad read and MAC stream signals of
//               the feature-map read sequencer. The master modport is the
//               sequencer side and the slave modport is its environment.
//               With FMAP_RD_PERF_CNT_EN defined, it also carries stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface fmap_read_seq_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int PARA_WIDTH         = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
) ();
  // Job control
  logic                          start;
  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_point;
  logic [PARA_WIDTH-1:0]         weight_num;
  logic [PARA_WIDTH-1:0]         out_num;
  logic                          busy;
  logic                          done;
  // Scratch-pad read port
  logic                          pad_data_ready;
  logic [ADDRESSWIDTH_F_PAD-1:0] raddra_ifmap;
  logic [DATA_WIDTH-1:0]         fmap_out;
  // MAC stream
  logic [DATA_WIDTH-1:0]         mac_data;
  logic [PARA_WIDTH-1:0]         mac_tap;
  logic                          mac_first;
  logic                          mac_last;
  logic                          mac_valid;
  logic                          mac_ready;
`ifdef FMAP_RD_PERF_CNT_EN
  logic [15:0]                   stall_cnt;
`endif

  modport master (
    input  start, pixel_point, weight_num, out_num, pad_data_ready,
           fmap_out, mac_ready,
`ifdef FMAP_RD_PERF_CNT_EN
    output stall_cnt,
`endif
    output raddra_ifmap, mac_data, mac_tap, mac_first, mac_last,
           mac_valid, busy, done
  );

  modport slave (
    output start, pixel_point, weight_num, out_num, pad_data_ready,
           fmap_out, mac_ready,
`ifdef FMAP_RD_PERF_CNT_EN
    input  stall_cnt,
`endif
    input  raddra_ifmap, mac_data, mac_tap, mac_first, mac_last,
           mac_valid, busy, done
  );
endinterface : fmap_read_seq_if
`default_nettype wire

// File: rtl/fmap_read_seq.sv
`default_nettype none
// ============================================================================
// Module      : fmap_read_seq
// Description : Scratch-pad read sequencer for a stride-1 1-D sliding window.
//               Issues reads at base+o+k (o outer over N outputs, k inner
//               over K taps), tags each returned pixel with its tap index and
//               streams it to the MAC array through a 2-entry buffer that
//               absorbs the 1-cycle scratch-pad latency.
//               Optional macro FMAP_RD_PERF_CNT_EN adds stall_cnt, a
//               saturating count of RUN cycles without a read issue.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_read_seq #(
  parameter int DATA_WIDTH         = 16,
  parameter int PARA_WIDTH         = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
) (
  input  logic            clk,
  input  logic            rst,
  fmap_read_seq_if.master bus
);

  localparam int c_ENTRY_W = DATA_WIDTH + PARA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Job parameters latched at an accepted start
  logic [ADDRESSWIDTH_F_PAD-1:0] r_base;
  logic [PARA_WIDTH-1:0]         r_k_num;
  logic [PARA_WIDTH-1:0]         r_o_num;
  // Window counters
  logic [PARA_WIDTH-1:0]         r_o;
  logic [PARA_WIDTH-1:0]         r_k;
  // Tags travelling alongside the read in flight
  logic                          r_rd_v;
  logic [PARA_WIDTH-1:0]         r_rd_tap;
  logic                          r_rd_first;
  logic                          r_rd_last;
  // Output buffer: r_buf0 is always the head
  logic [1:0]                    r_occ;
  logic [c_ENTRY_W-1:0]          r_buf0;
  logic [c_ENTRY_W-1:0]          r_buf1;

  logic                          w_start_ok;
  logic                          w_zero_job;
  logic                          w_pop;
  logic [2:0]                    w_fill;
  logic                          w_issue;
  logic                          w_k_end;
  logic                          w_o_end;
  logic                          w_last_issue;
  logic [c_ENTRY_W-1:0]          w_new;

  assign w_start_ok   = (r_state == S_IDLE) && bus.start;
  assign w_zero_job   = (bus.weight_num == '0) || (bus.out_num == '0);
  assign w_pop        = (r_occ != 2'd0) && bus.mac_ready;
  // Occupancy the buffer will have once the read in flight lands and the
  // current head (if accepted) leaves; a new read may only issue while this
  // leaves room for it.
  assign w_fill       = {1'b0, r_occ} + {2'b00, r_rd_v} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_RUN) && bus.pad_data_ready && (w_fill < 3'd2);
  assign w_k_end      = (r_k == r_k_num - PARA_WIDTH'(1));
  assign w_o_end      = (r_o == r_o_num - PARA_WIDTH'(1));
  assign w_last_issue = w_issue && w_k_end && w_o_end;
  assign w_new        = {bus.fmap_out, r_rd_tap, r_rd_first, r_rd_last};

  // Address is formed from the registered counters; it wraps naturally
  assign bus.raddra_ifmap = r_base + ADDRESSWIDTH_F_PAD'(r_o) + ADDRESSWIDTH_F_PAD'(r_k);

  assign {bus.mac_data, bus.mac_tap, bus.mac_first, bus.mac_last} = r_buf0;
  assign bus.mac_valid = (r_occ != 2'd0);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; an empty job passes through DRAIN so that its done
  // pulse lands on the same schedule as any other job that has drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = w_zero_job ? S_DRAIN : S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_rd_v && (w_fill == 3'd0)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the job at start and step the window counters on each issue;
  // the final issue leaves the counters in place so the address holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_k_num <= '0;
      r_o_num <= '0;
      r_o     <= '0;
      r_k     <= '0;
    end else if (w_start_ok) begin
      r_base  <= bus.pixel_point;
      r_k_num <= bus.weight_num;
      r_o_num <= bus.out_num;
      r_o     <= '0;
      r_k     <= '0;
    end else if (w_issue && !w_last_issue) begin
      if (w_k_end) begin
        r_k <= '0;
        r_o <= r_o + PARA_WIDTH'(1);
      end else begin
        r_k <= r_k + PARA_WIDTH'(1);
      end
    end
  end

  // Carry tap/first/last for the read whose data arrives next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_v     <= 1'b0;
      r_rd_tap   <= '0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_v     <= w_issue;
      r_rd_tap   <= r_k;
      r_rd_first <= (r_k == '0);
      r_rd_last  <= w_k_end;
    end
  end

  // Two-entry FIFO: returned pixels are pushed, MAC handshakes pop the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({r_rd_v, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= w_new;
          else               r_buf1 <= w_new;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= w_new;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FMAP_RD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  assign bus.stall_cnt = r_stall_cnt;

  // Saturating count of RUN cycles in which no read could be issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall_cnt <= '0;
    else if (w_start_ok)                      r_stall_cnt <= '0;
    else if ((r_state == S_RUN) && !w_issue && (r_stall_cnt != 16'hFFFF))
                                              r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif

endmodule : fmap_read_seq
`default_nettype wire
